// File: rtl/coproc_pkg.sv
// coproc_pkg -- shared definitions for the coprocessor bus.
//   Holds the dispatcher FSM state encoding, the bit positions of the
//   command and response words, and the reserved idle address, so the
//   slave side and the dispatcher agree on one bus layout.
package coproc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // Command word (dispatcher -> slaves): [31:30] device, [23:0] payload.
   localparam int ADDR_IN_HI  = 31;
   localparam int ADDR_IN_LO  = 30;
   // Response word (slaves -> dispatcher): [31] posted, [30:29] source.
   localparam int POST_BIT    = 31;
   localparam int ADDR_OUT_HI = 30;
   localparam int ADDR_OUT_LO = 29;
   localparam int PAYLOAD_W   = 24;

   // No slave is ever configured with this address.
   localparam logic [1:0] IDLE_ADDR_DFLT = 2'b11;

   function automatic logic [31:0] cmd_word(input logic [1:0]           dev,
                                            input logic [PAYLOAD_W-1:0] data);
      logic [31:0] w;
      w = '0;
      w[ADDR_IN_HI:ADDR_IN_LO] = dev;
      w[PAYLOAD_W-1:0]         = data;
      return w;
   endfunction

endpackage

// File: rtl/coproc_timeout_cnt.sv
// coproc_timeout_cnt -- WAIT-state cycle counter with terminal-count flag.
//   clk  : clock          rst : sync active-high reset
//   clr  : zero the count (wins over en)
//   en   : count up one
//   tc   : count == TIMEOUT_CYCLES-1
module coproc_timeout_cnt import coproc_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/coproc_dispatch.sv
// coproc_dispatch -- single-outstanding bus initiator for coprocessor slaves.
//   CPU side : req_valid/req_ready/req_dev/req_data in,
//              rsp_valid/rsp_dev/rsp_data/rsp_timeout/rsp_error out, busy.
//   Bus side : bus_out command word (device address is non-idle for the one
//              ISSUE cycle only), bus_in/bus_irq posted responses.
//   Build option COPROC_DISPATCH_RETRY_EN: the first timeout of a command
//   re-issues it once; only the second timeout is reported.
module coproc_dispatch import coproc_pkg::*; #(
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter int         CNT_W          = 16,
   parameter logic [1:0] IDLE_ADDR      = IDLE_ADDR_DFLT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_dev,
   input  logic [PAYLOAD_W-1:0] req_data,
   output logic [31:0]          bus_out,
   input  logic [31:0]          bus_in,
   input  logic                 bus_irq,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_dev,
   output logic [PAYLOAD_W-1:0] rsp_data,
   output logic                 rsp_timeout,
   output logic                 rsp_error,
   output logic                 busy
);

   localparam logic [31:0] IDLE_WORD = {IDLE_ADDR, 30'b0};

   state_t               state, state_nxt;
   logic [1:0]           cmd_dev, cmd_dev_nxt;
   logic [PAYLOAD_W-1:0] cmd_data, cmd_data_nxt;
   logic [31:0]          bus_out_nxt;
   logic                 rsp_valid_nxt, rsp_timeout_nxt, rsp_error_nxt, busy_nxt;
   logic [1:0]           rsp_dev_nxt;
   logic [PAYLOAD_W-1:0] rsp_data_nxt;
   logic                 tc, match, accept, bad_dev, expire, retry_now;
   logic                 unused_bus;

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign bad_dev   = (req_dev == IDLE_ADDR);
   assign match     = (state == ST_WAIT) && bus_irq && bus_in[POST_BIT] &&
                      (bus_in[ADDR_OUT_HI:ADDR_OUT_LO] == cmd_dev);
   assign unused_bus = ^bus_in[28:PAYLOAD_W];

   // Counter is held at zero outside WAIT, so re-entering ISSUE on a retry
   // restarts the full window.
   coproc_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_tmo (
      .clk(clk),
      .rst(rst),
      .clr(state != ST_WAIT),
      .en (state == ST_WAIT),
      .tc (tc)
   );

`ifdef COPROC_DISPATCH_RETRY_EN
   logic retry, retry_nxt;
   assign retry_now = (state == ST_WAIT) && tc && !match && !retry;
   assign expire    = (state == ST_WAIT) && tc && !match &&  retry;
`else
   assign retry_now = 1'b0;
   assign expire    = (state == ST_WAIT) && tc && !match;
`endif

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cmd_dev     <= '0;
         cmd_data    <= '0;
         bus_out     <= IDLE_WORD;
         rsp_valid   <= 1'b0;
         rsp_dev     <= '0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         rsp_error   <= 1'b0;
         busy        <= 1'b0;
`ifdef COPROC_DISPATCH_RETRY_EN
         retry       <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cmd_dev     <= cmd_dev_nxt;
         cmd_data    <= cmd_data_nxt;
         bus_out     <= bus_out_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_dev     <= rsp_dev_nxt;
         rsp_data    <= rsp_data_nxt;
         rsp_timeout <= rsp_timeout_nxt;
         rsp_error   <= rsp_error_nxt;
         busy        <= busy_nxt;
`ifdef COPROC_DISPATCH_RETRY_EN
         retry       <= retry_nxt;
`endif
      end
   end

   // Next state.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept && !bad_dev) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (match || expire) state_nxt = ST_IDLE;
            else if (retry_now)  state_nxt = ST_ISSUE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs. Default bus word is idle, so
   // only the paths into ISSUE ever put a device address on the bus.
   always_comb begin
      cmd_dev_nxt     = cmd_dev;
      cmd_data_nxt    = cmd_data;
      bus_out_nxt     = IDLE_WORD;
      rsp_valid_nxt   = 1'b0;
      rsp_dev_nxt     = rsp_dev;
      rsp_data_nxt    = rsp_data;
      rsp_timeout_nxt = rsp_timeout;
      rsp_error_nxt   = rsp_error;
      busy_nxt        = busy;
`ifdef COPROC_DISPATCH_RETRY_EN
      retry_nxt       = retry;
      if (accept)    retry_nxt = 1'b0;
      if (retry_now) retry_nxt = 1'b1;
`endif
      if (accept) begin
         cmd_dev_nxt  = req_dev;
         cmd_data_nxt = req_data;
         if (bad_dev) begin
            rsp_valid_nxt   = 1'b1;
            rsp_dev_nxt     = req_dev;
            rsp_data_nxt    = '0;
            rsp_timeout_nxt = 1'b0;
            rsp_error_nxt   = 1'b1;
         end else begin
            bus_out_nxt = cmd_word(req_dev, req_data);
            busy_nxt    = 1'b1;
         end
      end
      if (retry_now)
         bus_out_nxt = cmd_word(cmd_dev, cmd_data);
      // A match on the terminal-count cycle still reports success.
      if (match || expire) begin
         rsp_valid_nxt   = 1'b1;
         rsp_dev_nxt     = cmd_dev;
         rsp_data_nxt    = match ? bus_in[PAYLOAD_W-1:0] : '0;
         rsp_timeout_nxt = !match;
         rsp_error_nxt   = 1'b0;
         busy_nxt        = 1'b0;
      end
   end

endmodule

// File: doc/coproc_dispatch.md
Name: coproc_dispatch

Overview:
- Bus initiator that feeds the coprocessor bus slaves.
- Takes one command at a time from the CPU side as a valid/ready request (2-bit device address, 24-bit payload).
- Drives the command word onto the slave-facing 32-bit bus for exactly one cycle, then waits for the addressed slave's posted response.
- Returns either the response payload or a timeout to the CPU; one command outstanding at most.

Parameters:
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before a command is abandoned (range 2..65535).
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- IDLE_ADDR, 2'b11, reserved bus address driven when no command is active; no slave is configured with it.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU command request.
- req_ready  out  1  block can accept a command this cycle.
- req_dev  in  2  target device address.
- req_data  in  24  command payload.
- bus_out  out  32  command word to the slaves' 32-bit input.
- bus_in  in  32  response word from the slaves' 32-bit output: [31]=posted, [30:29]=source address, [23:0]=payload.
- bus_irq  in  1  response strobe from the slaves (one-cycle pulse per post).
- rsp_valid  out  1  one-cycle pulse: command finished.
- rsp_dev  out  2  device address of the finished command.
- rsp_data  out  24  response payload; 0 on timeout or error.
- rsp_timeout  out  1  qualifies rsp_valid: no response within TIMEOUT_CYCLES.
- rsp_error  out  1  qualifies rsp_valid: command rejected (req_dev == IDLE_ADDR).
- busy  out  1  high in ISSUE and WAIT.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - State goes to IDLE.
  - bus_out = {IDLE_ADDR, 30'b0}.
  - rsp_valid, rsp_timeout, rsp_error, rsp_dev, rsp_data, busy all 0; timeout counter 0.
  - Reset mid-command abandons it silently: no rsp_valid, and bus_out returns to idle on the next cycle.
- All outputs are registered except req_ready, which is (state == IDLE).
- IDLE:
  - On req_valid && req_ready, latch req_dev/req_data.
  - If req_dev == IDLE_ADDR: stay in IDLE and pulse rsp_valid with rsp_error=1 and rsp_data=0 on the next cycle; the bus is not driven.
  - Otherwise: bus_out <= {req_dev, 6'b0, req_data}, busy <= 1, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The command word is visible on bus_out for this cycle only.
  - On exit, bus_out <= {IDLE_ADDR, 30'b0}, counter <= 0, go to WAIT.
  - bus_irq is ignored in ISSUE, because any strobe seen here is stale.
- WAIT:
  - Match condition: bus_irq && bus_in[31] && bus_in[30:29] == latched dev.
  - On match: capture bus_in[23:0] into rsp_data, rsp_valid <= 1, timeout/error <= 0, busy <= 0, go to IDLE.
  - Non-matching strobes (other address, or bit31 clear) are ignored.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 without a match: rsp_valid <= 1, rsp_timeout <= 1, rsp_data <= 0, go to IDLE.
  - A match in the same cycle as the timeout terminal count takes priority; it is reported as success.
- Latency: request accepted at edge T; command on the bus during cycle T+1; earliest accepted strobe in cycle T+2; rsp_valid high the cycle after the matching strobe.
- rsp_valid is high for exactly one cycle. rsp_dev/rsp_data/rsp_timeout/rsp_error hold their values until the next completion.
- A new request can be accepted in the same cycle that rsp_valid is high (state is already IDLE).
- No bus_out word other than the ISSUE word ever carries a real device address.

Optional Feature:
- Macro: COPROC_DISPATCH_RETRY_EN.
- Defined: on the first timeout of a command, re-enter ISSUE once with the same word and a cleared counter. Only the second timeout reports rsp_timeout; a 1-bit retry flag, cleared on every accept, tracks this.
- Undefined: the first timeout completes the command as described above; no retry flag exists.

Decomposition:
- Shared package coproc_pkg holds:
  - State encoding (IDLE, ISSUE, WAIT).
  - Bus field positions: ADDR_IN_HI=31, ADDR_IN_LO=30, POST_BIT=31, ADDR_OUT_HI=30, ADDR_OUT_LO=29, PAYLOAD_W=24.
  - The IDLE_ADDR default, so the slave side and this block agree on the bus layout.
- One sub-module is natural: coproc_timeout_cnt (clear, enable, terminal-count flag, parameterised by TIMEOUT_CYCLES/CNT_W). Everything else stays in one FSM.

Test Plan:
- Dev 1, data 0x123456; slave model posts {1,01,5'b0,0xABCDEF} with irq 3 cycles after issue -> bus_out = 0x40123456 for exactly one cycle, then 0xC0000000; rsp_valid one cycle, rsp_dev=1, rsp_data=0xABCDEF, timeout=0, error=0.
- Dev 2 request; irq from dev 0 (bit31 set), then irq from dev 2 with bit31 clear, then a valid dev-2 post -> first two strobes ignored; single rsp_valid with the dev-2 payload.
- TIMEOUT_CYCLES=8, no response -> rsp_valid with rsp_timeout=1, rsp_data=0, exactly 8 WAIT cycles after ISSUE; req_ready high that same cycle. With COPROC_DISPATCH_RETRY_EN -> a second one-cycle issue is seen, and the timeout is reported after 2x8 WAIT cycles.
- Request with req_dev=3 -> no non-idle bus_out word; next cycle rsp_valid with rsp_error=1.
- rst asserted in WAIT, then a matching irq arrives -> no rsp_valid; bus_out=0xC0000000; req_ready=1 after reset.
- Back-to-back: a new req_valid held high through a completion -> accepted in the rsp_valid cycle; next bus_out command word appears the following cycle.
